// File: rtl/stream_pkg.sv
// Shared types and helpers for the stream_mux_nto1 slice: skid FSM encoding,
// default geometry and the round-robin next-index search.
package stream_pkg;

    localparam int DEFAULT_WIDTH    = 32;
    localparam int DEFAULT_CHANNELS = 4;
    localparam int MAX_CHANNELS     = 16;
    localparam int MAX_SEL_W        = $clog2(MAX_CHANNELS);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } skid_state_e;

    // Nearest channel above cur (wrapping, cur itself excluded) with valid set;
    // returns cur when no other channel is valid.
    function automatic int rr_next(int cur, logic [MAX_CHANNELS-1:0] valid, int n);
        logic [MAX_SEL_W-1:0] idx;
        rr_next = cur;
        for (int k = MAX_CHANNELS - 1; k >= 1; k--) begin
            if (k < n) begin
                idx = MAX_SEL_W'((cur + k) % n);
                if (valid[idx]) rr_next = int'(idx);
            end
        end
    endfunction

endpackage

// File: rtl/stream_mux_nto1_if.sv
// Handshake bundle between the N producers, the mux and the single consumer.
// master = producer/consumer side, slave = the mux itself.
interface stream_mux_nto1_if
    import stream_pkg::*;
#(
    parameter int WIDTH    = DEFAULT_WIDTH,
    parameter int CHANNELS = DEFAULT_CHANNELS
);
    localparam int SEL_W = $clog2(CHANNELS);

    logic [CHANNELS*WIDTH-1:0] in_data;
    logic [CHANNELS-1:0]       in_valid;
    logic [CHANNELS-1:0]       in_ready;
    logic [SEL_W-1:0]          sel;
    logic                      sel_load;
    logic [SEL_W-1:0]          cur_sel;
    logic                      sel_err;
    logic [WIDTH-1:0]          out_data;
    logic                      out_valid;
    logic                      out_ready;

    modport master (
        output in_data, in_valid, sel, sel_load, out_ready,
        input  in_ready, cur_sel, sel_err, out_data, out_valid
    );

    modport slave (
        input  in_data, in_valid, sel, sel_load, out_ready,
        output in_ready, cur_sel, sel_err, out_data, out_valid
    );

endinterface

// File: rtl/stream_skid_buf.sv
// Two-entry skid buffer: output register plus one skid slot, so a word accepted
// in the cycle backpressure appears is held rather than lost.
module stream_skid_buf
    import stream_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready
);

    skid_state_e      state_q, state_d;
    logic [WIDTH-1:0] out_q, skid_q;
    logic             accept, emit;

    assign accept   = in_valid && in_ready;
    assign emit     = out_valid && out_ready;
    assign out_data = out_q;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= EMPTY;
        else        state_q <= state_d;
    end

    // NOTE: state_d gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            EMPTY: if (accept) state_d = ONE;
            ONE: begin
                if (accept && !emit)      state_d = FULL;
                else if (emit && !accept) state_d = EMPTY;
            end
            FULL:    if (emit) state_d = ONE;
            default: state_d = EMPTY;
        endcase
    end

    always_comb begin
        in_ready  = (state_q != FULL);
        out_valid = (state_q != EMPTY);
    end

    // NOTE: the skid slot is reset along with the output register; it is a
    // single word, so clearing it keeps post-reset contents deterministic.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q  <= '0;
            skid_q <= '0;
        end else begin
            unique case (state_q)
                EMPTY: if (accept) out_q <= in_data;
                ONE: begin
                    if (accept && emit) out_q  <= in_data;
                    else if (accept)    skid_q <= in_data;
                end
                FULL:    if (emit) out_q <= skid_q;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/stream_mux_nto1.sv
// N:1 valid/ready stream mux with registered channel pointer, illegal-select
// flag and a 2-entry skid buffer. STREAM_MUX_RR_EN adds round-robin advance.
module stream_mux_nto1
    import stream_pkg::*;
#(
    parameter int WIDTH    = DEFAULT_WIDTH,
    parameter int CHANNELS = DEFAULT_CHANNELS
) (
    input  logic              clk,
    input  logic              rst_n,
`ifdef STREAM_MUX_RR_EN
    input  logic              rr_mode,
`endif
    stream_mux_nto1_if.slave  bus
);

    localparam int SEL_W = $clog2(CHANNELS);

    if (CHANNELS < 2 || CHANNELS > MAX_CHANNELS) begin : g_bad_channels
        $error("stream_mux_nto1: CHANNELS must be in 2..16");
    end

    logic [SEL_W-1:0] cur_sel_q;
    logic             sel_err_q;
    logic             sel_legal;
    logic [WIDTH-1:0] words [CHANNELS];
    logic             skid_in_ready;

    for (genvar c = 0; c < CHANNELS; c++) begin : g_words
        assign words[c] = bus.in_data[c*WIDTH +: WIDTH];
    end

    assign sel_legal    = 32'(bus.sel) < CHANNELS;
    assign bus.cur_sel  = cur_sel_q;
    assign bus.sel_err  = sel_err_q;

    // Only the pointed-to channel ever sees ready; the rest are held off.
    always_comb begin
        bus.in_ready            = '0;
        bus.in_ready[cur_sel_q] = skid_in_ready;
    end

`ifdef STREAM_MUX_RR_EN
    logic                    accept;
    logic [MAX_CHANNELS-1:0] valid_pad;

    assign accept = bus.in_valid[cur_sel_q] && skid_in_ready;

    always_comb begin
        valid_pad                = '0;
        valid_pad[CHANNELS-1:0]  = bus.in_valid;
    end
`endif

    // The pointer register makes a new selection take effect one cycle later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_sel_q <= '0;
            sel_err_q <= 1'b0;
        end else begin
            sel_err_q <= bus.sel_load && !sel_legal;
            if (bus.sel_load && sel_legal)
                cur_sel_q <= bus.sel;
`ifdef STREAM_MUX_RR_EN
            else if (!bus.sel_load && rr_mode && accept)
                cur_sel_q <= SEL_W'(rr_next(int'(cur_sel_q), valid_pad, CHANNELS));
`endif
        end
    end

    stream_skid_buf #(.WIDTH(WIDTH)) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (words[cur_sel_q]),
        .in_valid  (bus.in_valid[cur_sel_q]),
        .in_ready  (skid_in_ready),
        .out_data  (bus.out_data),
        .out_valid (bus.out_valid),
        .out_ready (bus.out_ready)
    );

endmodule

// File: tb/tb_stream_mux_nto1.sv
// Self-checking bench for stream_mux_nto1: a 2-deep queue model checked every
// cycle plus directed scenarios with literal expected output orders.
module tb_stream_mux_nto1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
`ifdef STREAM_MUX_RR_EN
    logic rr_mode = 1'b0;
    logic rr_mode_b = 1'b0;
`endif

    always #5 clk = ~clk;

    stream_mux_nto1_if #(.WIDTH(32), .CHANNELS(4)) a ();
    stream_mux_nto1_if #(.WIDTH(8),  .CHANNELS(6)) b ();

    stream_mux_nto1 #(.WIDTH(32), .CHANNELS(4)) dut_a (
        .clk     (clk),
        .rst_n   (rst_n),
`ifdef STREAM_MUX_RR_EN
        .rr_mode (rr_mode),
`endif
        .bus     (a)
    );

    stream_mux_nto1 #(.WIDTH(8), .CHANNELS(6)) dut_b (
        .clk     (clk),
        .rst_n   (rst_n),
`ifdef STREAM_MUX_RR_EN
        .rr_mode (rr_mode_b),
`endif
        .bus     (b)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(posedge clk) cyc++;

    // Model: accepted-but-not-emitted words as a queue of capacity 2.
    logic [31:0] mq[$];
    int          m_sel = 0;
    logic        m_err = 1'b0;
    logic [31:0] m_last = '0;
    logic [31:0] emitted[$];
    int          emit_cyc[$];
    logic [3:0]  m_ready;
    logic        m_acc;
    logic [31:0] m_word;
    bit          m_found;

    always @(negedge clk) begin
        if (!rst_n) begin
            mq.delete();
            m_sel  = 0;
            m_err  = 1'b0;
            m_last = '0;
        end else begin
            m_ready = (mq.size() < 2) ? 4'(1 << m_sel) : 4'b0;
            check("m_cur_sel",   64'(a.cur_sel),   64'(m_sel));
            check("m_sel_err",   64'(a.sel_err),   64'(m_err));
            check("m_out_valid", 64'(a.out_valid), 64'(mq.size() > 0));
            check("m_out_data",  64'(a.out_data),  64'((mq.size() > 0) ? mq[0] : m_last));
            check("m_in_ready",  64'(a.in_ready),  64'(m_ready));

            if (a.out_valid && a.out_ready) begin
                emitted.push_back(a.out_data);
                emit_cyc.push_back(cyc);
            end

            m_acc  = (mq.size() < 2) && a.in_valid[m_sel];
            m_word = a.in_data[m_sel*32 +: 32];
            if (mq.size() > 0 && a.out_ready) void'(mq.pop_front());
            if (m_acc) mq.push_back(m_word);
            if (mq.size() > 0) m_last = mq[0];

            m_err = a.sel_load && (int'(a.sel) >= 4);
            if (a.sel_load) begin
                if (int'(a.sel) < 4) m_sel = int'(a.sel);
            end
`ifdef STREAM_MUX_RR_EN
            else if (rr_mode && m_acc) begin
                m_found = 1'b0;
                for (int k = 1; k < 4; k++) begin
                    if (!m_found && a.in_valid[(m_sel + k) % 4]) begin
                        m_sel   = (m_sel + k) % 4;
                        m_found = 1'b1;
                    end
                end
            end
`endif
        end
    end

    task automatic check_seq(input string name, input logic [31:0] exp_q[$]);
        check({name, "_count"}, 64'(emitted.size()), 64'(exp_q.size()));
        foreach (exp_q[i]) begin
            if (i < emitted.size()) check($sformatf("%s_%0d", name, i), 64'(emitted[i]), 64'(exp_q[i]));
        end
    endtask

    logic [31:0] exp_q[$];

    initial begin
        a.in_data = '0; a.in_valid = '0; a.sel = '0; a.sel_load = 1'b0; a.out_ready = 1'b0;
        b.in_data = '0; b.in_valid = '0; b.sel = '0; b.sel_load = 1'b0; b.out_ready = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;

        // Reset / idle state
        check("rst_cur_sel",   64'(a.cur_sel),   64'(0));
        check("rst_out_valid", 64'(a.out_valid), 64'(0));
        check("rst_out_data",  64'(a.out_data),  64'(0));
        check("rst_in_ready",  64'(a.in_ready),  64'(4'b0001));
        check("rst_sel_err",   64'(a.sel_err),   64'(0));

        // First word, latency one
        a.out_ready = 1'b1;
        a.in_valid = 4'b0001;
        a.in_data[31:0] = 32'hDEADBEEF;
        tick();
        check("first_valid", 64'(a.out_valid), 64'(1));
        check("first_data",  64'(a.out_data),  64'(32'hDEADBEEF));
        a.in_valid = '0;
        tick();
        check("drain_valid", 64'(a.out_valid), 64'(0));
        check("hold_data",   64'(a.out_data),  64'(32'hDEADBEEF));

        // Streaming on channel 2 at full rate
        a.sel = 2'd2; a.sel_load = 1'b1;
        tick();
        a.sel_load = 1'b0;
        check("stream_cur_sel", 64'(a.cur_sel), 64'(2));
        emitted.delete(); emit_cyc.delete();
        for (int i = 1; i <= 8; i++) begin
            a.in_valid = 4'b0100;
            a.in_data[95:64] = 32'(i);
            tick();
        end
        a.in_valid = '0;
        repeat (2) tick();
        exp_q = '{32'h1, 32'h2, 32'h3, 32'h4, 32'h5, 32'h6, 32'h7, 32'h8};
        check_seq("stream", exp_q);
        if (emit_cyc.size() == 8) check("stream_no_bubble", 64'(emit_cyc[7] - emit_cyc[0]), 64'(7));

        // Backpressure on channel 1
        a.out_ready = 1'b0;
        a.sel = 2'd1; a.sel_load = 1'b1;
        tick();
        a.sel_load = 1'b0;
        emitted.delete();
        a.in_valid = 4'b0010;
        a.in_data[63:32] = 32'hA; tick();
        a.in_data[63:32] = 32'hB; tick();
        a.in_data[63:32] = 32'hC;
        check("bp_full_ready", 64'(a.in_ready), 64'(0));
        tick();
        check("bp_still_full", 64'(a.in_ready), 64'(0));
        a.out_ready = 1'b1;
        tick();
        check("bp_reopen", 64'(a.in_ready), 64'(4'b0010));
        tick();
        a.in_valid = '0;
        repeat (2) tick();
        exp_q = '{32'hA, 32'hB, 32'hC};
        check_seq("bp", exp_q);

        // Pointer switch while FULL
        a.out_ready = 1'b0;
        a.sel = 2'd0; a.sel_load = 1'b1;
        tick();
        a.sel_load = 1'b0;
        emitted.delete();
        a.in_valid = 4'b0001;
        a.in_data[31:0] = 32'h10; tick();
        a.in_data[31:0] = 32'h11; tick();
        a.in_valid = 4'b1000;
        a.in_data[127:96] = 32'h30;
        a.sel = 2'd3; a.sel_load = 1'b1;
        tick();
        a.sel_load = 1'b0;
        check("sw_cur_sel",  64'(a.cur_sel),  64'(3));
        check("sw_in_ready", 64'(a.in_ready), 64'(0));
        a.out_ready = 1'b1;
        repeat (2) tick();
        a.in_valid = '0;
        repeat (2) tick();
        exp_q = '{32'h10, 32'h11, 32'h30};
        check_seq("switch", exp_q);

        // Illegal select on the 6-channel instance
        b.sel = 3'd7; b.sel_load = 1'b1;
        tick();
        b.sel_load = 1'b0;
        check("ill_err_pulse", 64'(b.sel_err), 64'(1));
        check("ill_cur_sel",   64'(b.cur_sel), 64'(0));
        tick();
        check("ill_err_clear", 64'(b.sel_err), 64'(0));
        b.sel = 3'd5; b.sel_load = 1'b1;
        tick();
        b.sel_load = 1'b0;
        check("legal5_cur_sel",  64'(b.cur_sel),  64'(5));
        check("legal5_in_ready", 64'(b.in_ready), 64'(6'b100000));
        check("legal5_no_err",   64'(b.sel_err),  64'(0));
        b.sel = 3'd6; b.sel_load = 1'b1;
        tick();
        b.sel_load = 1'b0;
        check("ill6_err",     64'(b.sel_err), 64'(1));
        check("ill6_cur_sel", 64'(b.cur_sel), 64'(5));
        tick();
        check("ill6_clear",   64'(b.sel_err), 64'(0));

        // Asynchronous reset with two words buffered
        a.out_ready = 1'b0;
        a.sel = 2'd1; a.sel_load = 1'b1;
        tick();
        a.sel_load = 1'b0;
        a.in_valid = 4'b0010;
        a.in_data[63:32] = 32'h55; tick();
        a.in_data[63:32] = 32'h66; tick();
        a.in_valid = '0;
        check("pre_rst_valid", 64'(a.out_valid), 64'(1));
        #2 rst_n = 1'b0;
        #1;
        check("arst_out_valid", 64'(a.out_valid), 64'(0));
        check("arst_cur_sel",   64'(a.cur_sel),   64'(0));
        check("arst_out_data",  64'(a.out_data),  64'(0));
        check("arst_in_ready",  64'(a.in_ready),  64'(4'b0001));
        tick();
        rst_n = 1'b1;
        a.out_ready = 1'b1;
        tick();
        check("post_rst_empty", 64'(a.out_valid), 64'(0));

`ifdef STREAM_MUX_RR_EN
        // Round-robin walk with every channel valid
        rr_mode = 1'b1;
        a.in_valid = 4'b1111;
        check("rr_start", 64'(a.cur_sel), 64'(0));
        for (int k = 1; k <= 4; k++) begin
            tick();
            check($sformatf("rr_step%0d", k), 64'(a.cur_sel), 64'(k % 4));
        end
        rr_mode = 1'b0;
        a.in_valid = '0;
        repeat (2) tick();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
